memory_access_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the decode/execute control path and the memory controller. It accepts one load or store request at a time and drives the controller's `memoryMode` through the required cycle sequence: LOAD then capture for loads, STORE_PRELOAD then STORE for stores. It captures load results into a register-file write port and converts the controller's error flags into a sticky halt.

---
 rtl/memory_access_sequencer.sv | 165 ++++++++++++++++
 tb/tb_memory_access_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access_sequencer.sv
// Load/store sequencer that drives memoryMode through LOAD/capture or STORE_PRELOAD/STORE and traps controller errors into a sticky halt.
// Optional feature macro: JZJCOREF_FAST_WORD_STORE_EN (SW stores skip STORE_PRELOAD).
package memory_access_sequencer_pkg;
   typedef enum logic [1:0] {
      MM_LOAD          = 2'd0,
      MM_STORE_PRELOAD = 2'd1,
      MM_STORE         = 2'd2
   } MemoryMode_t;
endpackage

module memory_access_sequencer
   import memory_access_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        isStore,
   input  logic [2:0]  funct3,
   output MemoryMode_t memoryMode,
   output logic [2:0]  memoryFunct3,
   input  logic [31:0] memoryOutput,
   input  logic        memoryUnalignedAccess,
   input  logic        memoryBadFunct3,
   output logic        busy,
   output logic        done,
   output logic        rdWriteEnable,
   output logic [31:0] rdData,
   output logic        halted,
   output logic [1:0]  errorCause
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned CAUSE_W = 2;
   localparam logic [F3_W-1:0] F3_SW = F3_W'(3'b010);

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_LOAD_ISSUE   = 3'd1,
      ST_LOAD_CAPTURE = 3'd2,
      ST_PRELOAD      = 3'd3,
      ST_STORE        = 3'd4,
      ST_DONE         = 3'd5,
      ST_HALT         = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   MemoryMode_t          w_mode;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_trap;
   logic                 w_err;
   logic                 w_fast_store;

   logic                 r_is_store;
   logic [F3_W-1:0]      r_funct3;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_rd_we;
   logic [DATA_W-1:0]    r_rd_data;
   logic                 r_halted;
   logic [CAUSE_W-1:0]   r_cause;

`ifdef JZJCOREF_FAST_WORD_STORE_EN
   assign w_fast_store = (funct3 == F3_SW);
`else
   assign w_fast_store = 1'b0;
`endif

   assign w_err = memoryUnalignedAccess | memoryBadFunct3;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next state and combinational mode; any error in an active state forces LOAD so no write escapes
   always_comb begin
      w_next_state = r_state;
      w_mode       = MM_LOAD;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_trap       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (isStore) w_next_state = w_fast_store ? ST_STORE : ST_PRELOAD;
               else         w_next_state = ST_LOAD_ISSUE;
            end
         end
         ST_LOAD_ISSUE: begin
            if (w_err) w_trap = 1'b1;
            else       w_next_state = ST_LOAD_CAPTURE;
         end
         ST_LOAD_CAPTURE: begin
            if (w_err) begin
               w_trap = 1'b1;
            end else begin
               w_capture    = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_PRELOAD: begin
            if (w_err) begin
               w_trap = 1'b1;
            end else begin
               w_mode       = MM_STORE_PRELOAD;
               w_next_state = ST_STORE;
            end
         end
         ST_STORE: begin
            if (w_err) begin
               w_trap = 1'b1;
            end else begin
               w_mode       = MM_STORE;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE:  w_next_state = ST_IDLE;
         ST_HALT:  w_next_state = ST_HALT;
         default:  w_next_state = ST_IDLE;
      endcase
      if (w_trap) w_next_state = ST_HALT;
   end

   // Registered status, request latch, load capture and sticky error
   always_ff @(posedge clock) begin
      if (reset) begin
         r_is_store <= 1'b0;
         r_funct3   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_we    <= 1'b0;
         r_rd_data  <= '0;
         r_halted   <= 1'b0;
         r_cause    <= '0;
      end else begin
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (w_next_state == ST_DONE);
         r_rd_we <= (w_next_state == ST_DONE) && !r_is_store;
         if (w_accept) begin
            r_is_store <= isStore;
            r_funct3   <= funct3;
         end
         if (w_capture) r_rd_data <= memoryOutput;
         if (w_trap) begin
            r_halted <= 1'b1;
            r_cause  <= {memoryBadFunct3, memoryUnalignedAccess};
         end
      end
   end

   assign memoryMode    = w_mode;
   assign memoryFunct3  = r_funct3;
   assign busy          = r_busy;
   assign done          = r_done;
   assign rdWriteEnable = r_rd_we;
   assign rdData        = r_rd_data;
   assign halted        = r_halted;
   assign errorCause    = r_cause;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Randomized bench for memory_access_sequencer against a transaction-level model of the mode sequence.
module tb_memory_access_sequencer;
   import memory_access_sequencer_pkg::*;

`ifdef JZJCOREF_FAST_WORD_STORE_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        isStore;
   logic [2:0]  funct3;
   MemoryMode_t memoryMode;
   logic [2:0]  memoryFunct3;
   logic [31:0] memoryOutput;
   logic        memoryUnalignedAccess;
   logic        memoryBadFunct3;
   logic        busy;
   logic        done;
   logic        rdWriteEnable;
   logic [31:0] rdData;
   logic        halted;
   logic [1:0]  errorCause;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_rd = 32'h0;

   memory_access_sequencer dut (
      .clock(clock), .reset(reset), .start(start), .isStore(isStore), .funct3(funct3),
      .memoryMode(memoryMode), .memoryFunct3(memoryFunct3), .memoryOutput(memoryOutput),
      .memoryUnalignedAccess(memoryUnalignedAccess), .memoryBadFunct3(memoryBadFunct3),
      .busy(busy), .done(done), .rdWriteEnable(rdWriteEnable), .rdData(rdData),
      .halted(halted), .errorCause(errorCause)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One cycle: inputs change at negedge, outputs sampled 1ns later
   task automatic drive(input logic r, input logic s, input logic st, input logic [2:0] f3,
                        input logic ua, input logic bf, input logic [31:0] mo);
      @(negedge clock);
      reset = r; start = s; isStore = st; funct3 = f3;
      memoryUnalignedAccess = ua; memoryBadFunct3 = bf; memoryOutput = mo;
      #1;
   endtask

   task automatic check_outs(input string tag, input MemoryMode_t m, input logic b,
                             input logic d, input logic we);
      check({tag, ".mode"}, 32'(memoryMode), 32'(m));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".we"},   32'(rdWriteEnable), 32'(we));
   endtask

   task automatic check_reset_state(input string tag);
      check_outs(tag, MM_LOAD, 1'b0, 1'b0, 1'b0);
      check({tag, ".f3"},     32'(memoryFunct3), 32'h0);
      check({tag, ".rd"},     rdData, 32'h0);
      check({tag, ".halted"}, 32'(halted), 32'h0);
      check({tag, ".cause"},  32'(errorCause), 32'h0);
   endtask

   task automatic apply_reset();
      drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0, 1'b0, $urandom);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $urandom);
      exp_rd = 32'h0;
      check_reset_state("post_reset");
   endtask

   // One request; inject=1 raises error flags in a random active cycle
   task automatic run_req(input bit is_st, input logic [2:0] f3, input logic [31:0] data,
                          input bit inject, input logic [1:0] flags);
      MemoryMode_t modes[$];
      int          err_step;
      logic        ua;
      logic        bf;
      if (!is_st)                      modes = '{MM_LOAD, MM_LOAD};
      else if (FAST && f3 == 3'b010)   modes = '{MM_STORE};
      else                             modes = '{MM_STORE_PRELOAD, MM_STORE};
      err_step = inject ? $urandom_range(1, modes.size()) : 0;

      drive(1'b0, 1'b1, is_st, f3, 1'b0, 1'b0, $urandom);
      check_outs("accept", MM_LOAD, 1'b0, 1'b0, 1'b0);
      check("accept.rd", rdData, exp_rd);

      for (int i = 1; i <= modes.size(); i++) begin
         ua = (i == err_step) ? flags[0] : 1'b0;
         bf = (i == err_step) ? flags[1] : 1'b0;
         drive(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), ua, bf,
               (!is_st && i == 2) ? data : $urandom);
         check("active.f3", 32'(memoryFunct3), 32'(f3));
         if (i == err_step) begin
            check_outs("err_cycle", MM_LOAD, 1'b1, 1'b0, 1'b0);
            for (int h = 0; h < 4; h++) begin
               drive(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom);
               check_outs("halt", MM_LOAD, 1'b1, 1'b0, 1'b0);
               check("halt.halted", 32'(halted), 32'h1);
               check("halt.cause", 32'(errorCause), 32'(flags));
            end
            apply_reset();
            return;
         end
         check_outs("active", modes[i-1], 1'b1, 1'b0, 1'b0);
      end

      drive(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0, 1'b0, $urandom);
      if (!is_st) exp_rd = data;
      check_outs("done", MM_LOAD, 1'b1, 1'b1, !is_st);
      check("done.rd", rdData, exp_rd);
      check("done.halted", 32'(halted), 32'h0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; isStore = 1'b0; funct3 = 3'd0;
      memoryUnalignedAccess = 1'b0; memoryBadFunct3 = 1'b0; memoryOutput = 32'h0;
      drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $urandom);
         check_reset_state("idle");
      end

      run_req(1'b0, 3'b010, 32'hDEADBEEF, 1'b0, 2'b00);
      run_req(1'b1, 3'b000, 32'h0, 1'b0, 2'b00);
      run_req(1'b1, 3'b010, 32'h0, 1'b0, 2'b00);
      run_req(1'b0, 3'b100, 32'h12345678, 1'b0, 2'b00);

      // Unaligned flag during STORE_PRELOAD must trap before STORE is ever driven
      drive(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, $urandom);
      check_outs("ua_accept", MM_LOAD, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, $urandom);
      check_outs("ua_preload", MM_LOAD, 1'b1, 1'b0, 1'b0);
      for (int h = 0; h < 3; h++) begin
         drive(1'b0, 1'b1, 1'($urandom), 3'($urandom), 1'b0, 1'b0, $urandom);
         check_outs("ua_halt", MM_LOAD, 1'b1, 1'b0, 1'b0);
         check("ua_halt.halted", 32'(halted), 32'h1);
         check("ua_halt.cause", 32'(errorCause), 32'h1);
      end
      apply_reset();

      // Reset coinciding with STORE still shows STORE that cycle
      run_req(1'b0, 3'b010, 32'hCAFEF00D, 1'b0, 2'b00);
      drive(1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, $urandom);
      drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $urandom);
      check_outs("rs_pre", MM_STORE_PRELOAD, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $urandom);
      check("rs_store.mode", 32'(memoryMode), 32'(MM_STORE));
      drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, $urandom);
      exp_rd = 32'h0;
      check_reset_state("rs_after");

      for (int n = 0; n < 300; n++) begin
         bit         st;
         bit         inj;
         logic [1:0] fl;
         st  = 1'($urandom);
         inj = ($urandom_range(0, 7) == 0);
         fl  = 2'($urandom_range(1, 3));
         run_req(st, 3'($urandom), $urandom, inj, fl);
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), $urandom);
            check_outs("gap", MM_LOAD, 1'b0, 1'b0, 1'b0);
            check("gap.rd", rdData, exp_rd);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
